// File: rtl/alu_rr_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
// Holds the datapath widths, the ALU control codes and the output-register state encoding.
package alu_rr_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PERF_W = 16;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu32.sv
// ALU32: shared combinational 32-bit ALU.
// Ports: in0/in1 operands, ALUCtrl control code, ALUOut result, Zero (ALUOut == 0).
// Unknown control codes yield a zero result.
module ALU32
  import alu_rr_pkg::*;
(
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [OP_W-1:0]   ALUCtrl,
  output logic [DATA_W-1:0] ALUOut,
  output logic              Zero
);

  always_comb begin
    ALUOut = '0;
    case (ALUCtrl)
      OP_AND:  ALUOut = in0 & in1;
      OP_OR:   ALUOut = in0 | in1;
      OP_ADD:  ALUOut = in0 + in1;
      OP_SUB:  ALUOut = in0 - in1;
      OP_SLT:  ALUOut = {{(DATA_W-1){1'b0}}, (in0 < in1)};
      OP_NOR:  ALUOut = ~(in0 | in1);
      default: ALUOut = '0;
    endcase
    Zero = (ALUOut == '0);
  end

endmodule

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports: req request vector, pointer (highest-priority index), enable (gates all grants),
//        grant one-hot, grant_idx encoded winner, any_grant.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] pointer,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  // Scan N positions starting at pointer, wrapping; first requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(pointer) + k;
      if (idx >= N) idx = idx - N;
      if (enable && !any_grant && req[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        grant_idx          = IDX_W'(idx);
        any_grant          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one ALU32 among NUM_REQ requesters through a round-robin
// arbiter and a one-entry valid/ready output register.
// Ports: clk, rst_n (async active-low); req_valid/req_ready per requester;
//        req_in0/req_in1 packed 32-bit operands, req_op packed 4-bit codes;
//        rsp_valid/rsp_ready result handshake; rsp_data, rsp_zero, rsp_id result fields.
// Optional: define ALU_RR_SCHED_PERF_EN to add perf_grants/perf_stalls saturating counters.
module alu_rr_scheduler
  import alu_rr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in0,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic [ID_W-1:0]           rsp_id
`ifdef ALU_RR_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_grants,
  output logic [PERF_W-1:0]         perf_stalls
`endif
);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     ptr_d;
  logic                can_accept;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                xfer;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_zero;

  // Output slot is free if empty or being drained this cycle.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .enable    (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (xfer)
  );

  // Grant is suppressed while reset is held so no requester sees a phantom accept.
  assign req_ready = grant & {NUM_REQ{rst_n}};

  // Steer the winner's operands into the shared ALU.
  assign alu_a  = req_in0[32'(grant_idx)*DATA_W +: DATA_W];
  assign alu_b  = req_in1[32'(grant_idx)*DATA_W +: DATA_W];
  assign alu_op = req_op[32'(grant_idx)*OP_W +: OP_W];

  ALU32 u_alu (
    .in0     (alu_a),
    .in1     (alu_b),
    .ALUCtrl (alu_op),
    .ALUOut  (alu_out),
    .Zero    (alu_zero)
  );

  assign ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : ID_W'(grant_idx + 1'b1);

  // Output register, state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_id   <= '0;
    end else if (xfer) begin
      state_q  <= ST_FULL;
      ptr_q    <= ptr_d;
      rsp_data <= alu_out;
      rsp_zero <= alu_zero;
      rsp_id   <= grant_idx;
    end else if (rsp_ready) begin
      state_q  <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

`ifdef ALU_RR_SCHED_PERF_EN
  // Saturating transfer and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (xfer && (perf_grants != '1)) perf_grants <= perf_grants + 1'b1;
      if (!xfer && (|req_valid) && (perf_stalls != '1)) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule
